// File: rtl/dsp_p_out_skid.sv
// Output drain stage for the DSP48A1 slice model. It hands P/CARRYOUT results
// to a downstream consumer over valid/ready. With OUT_REG=1 a 2-entry skid
// buffer absorbs one cycle of back-pressure. With OUT_REG=0 the stage is a
// wire-through. The DSP pipeline cannot stall, so results that cannot be taken
// are dropped and counted in a saturating counter.
//
// state | meaning
// EMPTY | no result held, out_valid low
// ONE   | head result in main register
// TWO   | main holds head, skid holds next; input is refused
module dsp_p_out_skid #(
   parameter int P_WIDTH   = 48,
   parameter int OUT_REG   = 1,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ce,
   input  logic                 in_valid,
   input  logic [P_WIDTH-1:0]   in_p,
   input  logic                 in_carry,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [P_WIDTH-1:0]   out_p,
   output logic                 out_carry,
   output logic [CNT_WIDTH-1:0] drop_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic drop;

   // saturating count of results the stage could not take
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != {CNT_WIDTH{1'b1}})) begin
         drop_cnt <= drop_cnt + CNT_ONE;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_reg
         typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

         state_t             state;
         logic [P_WIDTH-1:0] main_p;
         logic               main_c;
         logic [P_WIDTH-1:0] skid_p;
         logic               skid_c;
         logic               push;
         logic               pop;

         // in_ready depends on registered state only, never on out_ready
         assign in_ready  = (state != TWO);
         assign out_valid = (state != EMPTY);
         assign out_p     = main_p;
         assign out_carry = main_c;

         assign push = in_valid & in_ready & ce;
         assign pop  = out_valid & out_ready & ce;
         assign drop = in_valid & ~in_ready & ce;

         // skid buffer FSM; P and carry always move together
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state  <= EMPTY;
               main_p <= '0;
               main_c <= 1'b0;
               skid_p <= '0;
               skid_c <= 1'b0;
            end else begin
               case (state)
                  EMPTY: begin
                     if (push) begin
                        main_p <= in_p;
                        main_c <= in_carry;
                        state  <= ONE;
                     end
                  end
                  ONE: begin
                     if (push && pop) begin
                        main_p <= in_p;
                        main_c <= in_carry;
                     end else if (push) begin
                        skid_p <= in_p;
                        skid_c <= in_carry;
                        state  <= TWO;
                     end else if (pop) begin
                        state  <= EMPTY;
                     end
                  end
                  TWO: begin
                     if (pop) begin
                        main_p <= skid_p;
                        main_c <= skid_c;
                        state  <= ONE;
                     end
                  end
                  default: state <= EMPTY;
               endcase
            end
         end
      end else begin : g_pass
         assign out_valid = in_valid;
         assign out_p     = in_p;
         assign out_carry = in_carry;
         assign in_ready  = out_ready;
         assign drop      = ce & in_valid & ~out_ready;
      end
   endgenerate

endmodule

// File: tb/tb_dsp_p_out_skid.sv
// Bench for dsp_p_out_skid: a registered instance checked through an expected
// queue and handshake monitor, plus a pass-through instance checked directly.
module tb_dsp_p_out_skid;

   localparam int PW = 48;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;

   logic          ce, in_valid, in_carry, out_ready;
   logic [PW-1:0] in_p;
   logic          in_ready, out_valid, out_carry;
   logic [PW-1:0] out_p;
   logic [CW-1:0] drop_cnt;

   logic          ce_b, in_valid_b, in_carry_b, out_ready_b;
   logic [PW-1:0] in_p_b;
   logic          in_ready_b, out_valid_b, out_carry_b;
   logic [PW-1:0] out_p_b;
   logic [CW-1:0] drop_cnt_b;

   int total = 0;
   int bad   = 0;

   logic [PW:0] exp_q [$];

   always #5 clk = ~clk;

   dsp_p_out_skid #(.P_WIDTH(PW), .OUT_REG(1), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_p(in_p),
      .in_carry(in_carry), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_p(out_p), .out_carry(out_carry),
      .drop_cnt(drop_cnt)
   );

   dsp_p_out_skid #(.P_WIDTH(PW), .OUT_REG(0), .CNT_WIDTH(CW)) dut_pass (
      .clk(clk), .rst_n(rst_n), .ce(ce_b), .in_valid(in_valid_b), .in_p(in_p_b),
      .in_carry(in_carry_b), .in_ready(in_ready_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .out_p(out_p_b), .out_carry(out_carry_b),
      .drop_cnt(drop_cnt_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // pop the expected queue on every accepted handshake
   always @(negedge clk) begin
      if (rst_n && ce && out_valid && out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_out: got p=0x%0h c=%0b expected none", out_p, out_carry);
         end else begin
            logic [PW:0] e;
            e = exp_q.pop_front();
            if ({out_carry, out_p} !== e) begin
               bad++;
               $display("FAIL out_data: got c=%0b p=0x%0h expected c=%0b p=0x%0h",
                        out_carry, out_p, e[PW], e[PW-1:0]);
            end
         end
      end
   end

   // one cycle on the registered instance; inputs change just after the edge
   task automatic step(input logic v, input logic [PW-1:0] p, input logic c, input logic accept);
      in_valid = v;
      in_p     = p;
      in_carry = c;
      if (accept) exp_q.push_back({c, p});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      ce = 1'b1; in_valid = 1'b0; in_p = '0; in_carry = 1'b0; out_ready = 1'b1;
      ce_b = 1'b1; in_valid_b = 1'b0; in_p_b = '0; in_carry_b = 1'b0; out_ready_b = 1'b1;
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      check("rst_out_p", 64'(out_p), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: single result, one-cycle latency
      step(1'b1, 48'h1, 1'b1, 1'b1);
      check("t1_out_valid", 64'(out_valid), 64'd1);
      check("t1_out_p", 64'(out_p), 64'h1);
      check("t1_out_carry", 64'(out_carry), 64'd1);
      idle(1);
      check("t1_empty", 64'(out_valid), 64'd0);
      check("t1_drop", 64'(drop_cnt), 64'd0);

      // 2: back-pressure fills the skid, then drains in order
      out_ready = 1'b0;
      step(1'b1, 48'hA, 1'b0, 1'b1);
      step(1'b1, 48'hB, 1'b1, 1'b1);
      in_valid = 1'b0;
      check("t2_in_ready", 64'(in_ready), 64'd0);
      check("t2_head", 64'(out_p), 64'hA);
      out_ready = 1'b1;
      idle(2);
      check("t2_drained", 64'(out_valid), 64'd0);
      check("t2_in_ready_after", 64'(in_ready), 64'd1);

      // 3: offers while full are dropped
      out_ready = 1'b0;
      step(1'b1, 48'hA, 1'b0, 1'b1);
      step(1'b1, 48'hB, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 48'hC, 1'b1, 1'b0);
      in_valid = 1'b0;
      check("t3_drop_cnt", 64'(drop_cnt), 64'd3);
      check("t3_head", 64'(out_p), 64'hA);
      out_ready = 1'b1;
      idle(3);
      check("t3_drained", 64'(out_valid), 64'd0);

      // 4: ce low freezes everything
      out_ready = 1'b0;
      step(1'b1, 48'h5, 1'b1, 1'b1);
      ce = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 48'h9, 1'b0, 1'b0);
         check("t4_out_p", 64'(out_p), 64'h5);
         check("t4_out_valid", 64'(out_valid), 64'd1);
         check("t4_drop_cnt", 64'(drop_cnt), 64'd3);
      end
      in_valid = 1'b0;
      ce = 1'b1;
      idle(2);
      check("t4_drained", 64'(out_valid), 64'd0);

      // 5: saturation, then asynchronous reset mid-cycle
      out_ready = 1'b0;
      step(1'b1, 48'hA, 1'b0, 1'b1);
      step(1'b1, 48'hB, 1'b0, 1'b1);
      for (int i = 0; i < 251; i++) step(1'b1, 48'hD, 1'b0, 1'b0);
      check("t5_drop_254", 64'(drop_cnt), 64'd254);
      for (int i = 0; i < 300; i++) step(1'b1, 48'hD, 1'b0, 1'b0);
      check("t5_drop_sat", 64'(drop_cnt), 64'd255);
      check("t5_full", 64'(in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("t5_rst_drop", 64'(drop_cnt), 64'd0);
      check("t5_rst_valid", 64'(out_valid), 64'd0);
      check("t5_rst_ready", 64'(in_ready), 64'd1);
      check("t5_rst_p", 64'(out_p), 64'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b1, 48'h3, 1'b0, 1'b1);
      in_valid = 1'b0;
      check("t5_post_head", 64'(out_p), 64'h3);
      idle(1);

      // 6: pass-through instance
      check("t6_rst_drop", 64'(drop_cnt_b), 64'd0);
      in_valid_b = 1'b1; in_p_b = 48'h7; in_carry_b = 1'b1; out_ready_b = 1'b0;
      #1;
      check("t6_out_valid", 64'(out_valid_b), 64'd1);
      check("t6_out_p", 64'(out_p_b), 64'h7);
      check("t6_out_carry", 64'(out_carry_b), 64'd1);
      check("t6_in_ready", 64'(in_ready_b), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      in_valid_b = 1'b0;
      check("t6_drop_cnt", 64'(drop_cnt_b), 64'd2);
      out_ready_b = 1'b1;
      #1;
      check("t6_in_ready_hi", 64'(in_ready_b), 64'd1);
      check("t6_out_valid_lo", 64'(out_valid_b), 64'd0);

      // every queued result must have been delivered within a bounded window
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
